// File: rtl/fetch_insn_read_stage.sv
// Fetch read stage: takes translated fetch PCs and reads the instruction from memory.
// On a TLB miss it requests a page walk, and on a translation fault it forwards the fault.
module fetch_insn_read_stage #(
    parameter int unsigned VADDR_WIDTH = 32,
    parameter int unsigned PADDR_WIDTH = 34,
    parameter int unsigned INSN_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   prev_valid,
    input  logic                   prev_tlbFault,
    input  logic                   prev_tlbMiss,
    input  logic [VADDR_WIDTH-1:0] prev_pc_vaddr,
    input  logic [PADDR_WIDTH-1:0] prev_pc_paddr,
    output logic                   stall,
    input  logic                   flush,
    output logic                   walk_req,
    output logic [VADDR_WIDTH-1:0] walk_vaddr,
    input  logic                   walk_done,
    output logic                   replay,
    output logic [VADDR_WIDTH-1:0] replay_vaddr,
    output logic                   mem_req,
    output logic [PADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [INSN_WIDTH-1:0]  mem_rdata,
    output logic                   next_valid,
    output logic [VADDR_WIDTH-1:0] next_pc,
    output logic [INSN_WIDTH-1:0]  next_insn,
    output logic                   next_fault,
    input  logic                   next_stall
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WALK  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t                 state;
    logic [VADDR_WIDTH-1:0] vaddr_q;
    logic [PADDR_WIDTH-1:0] paddr_q;
    logic                   drain_walk;
    logic                   ready_c;
    logic                   acc_c;

    // The stage can take a new entry when empty or when the current entry leaves this cycle
    assign ready_c = (state == IDLE) || ((state == OUT) && !next_stall);
    assign stall   = !ready_c;
    assign acc_c   = prev_valid && !flush && ready_c;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            vaddr_q      <= '0;
            paddr_q      <= '0;
            drain_walk   <= 1'b0;
            walk_req     <= 1'b0;
            walk_vaddr   <= '0;
            replay       <= 1'b0;
            replay_vaddr <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            next_valid   <= 1'b0;
            next_pc      <= '0;
            next_insn    <= '0;
            next_fault   <= 1'b0;
        end else begin
            replay <= 1'b0;
            if (flush && (state != DRAIN)) begin
                // An outstanding read or walk must still complete, so drain it silently
                case (state)
                    WALK: begin
                        if (walk_done) begin
                            walk_req <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            drain_walk <= 1'b1;
                            state      <= DRAIN;
                        end
                    end
                    REQ: begin
                        mem_req <= 1'b0;
                        if (mem_gnt) begin
                            drain_walk <= 1'b0;
                            state      <= DRAIN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            state <= IDLE;
                        end else begin
                            drain_walk <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                    default: begin
                        next_valid <= 1'b0;
                        mem_req    <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end else begin
                case (state)
                    IDLE, OUT: begin
                        if ((state == OUT) && !next_stall) begin
                            next_valid <= 1'b0;
                            state      <= IDLE;
                        end
                        if (acc_c) begin
                            vaddr_q <= prev_pc_vaddr;
                            paddr_q <= prev_pc_paddr;
                            if (prev_tlbFault) begin
                                next_valid <= 1'b1;
                                next_pc    <= prev_pc_vaddr;
                                next_insn  <= '0;
                                next_fault <= 1'b1;
                                state      <= OUT;
                            end else if (prev_tlbMiss) begin
                                walk_req   <= 1'b1;
                                walk_vaddr <= prev_pc_vaddr;
                                state      <= WALK;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_addr <= prev_pc_paddr;
                                state    <= REQ;
                            end
                        end
                    end
                    WALK: begin
                        if (walk_done) begin
                            walk_req     <= 1'b0;
                            replay       <= 1'b1;
                            replay_vaddr <= vaddr_q;
                            state        <= IDLE;
                        end
                    end
                    REQ: begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            next_valid <= 1'b1;
                            next_pc    <= vaddr_q;
                            next_insn  <= mem_rdata;
                            next_fault <= 1'b0;
                            state      <= OUT;
                        end
                    end
                    DRAIN: begin
                        if (drain_walk ? walk_done : mem_rvalid) begin
                            walk_req   <= 1'b0;
                            drain_walk <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_insn_read_stage.sv
// Self-checking bench for fetch_insn_read_stage: directed scenarios followed by random fetches
// checked against a transaction-level expectation of each fetch's outcome.
module tb_fetch_insn_read_stage;

    localparam int unsigned VW = 32;
    localparam int unsigned PW = 34;
    localparam int unsigned IW = 32;

    logic          clk;
    logic          rstN;
    logic          prev_valid;
    logic          prev_tlbFault;
    logic          prev_tlbMiss;
    logic [VW-1:0] prev_pc_vaddr;
    logic [PW-1:0] prev_pc_paddr;
    logic          stall;
    logic          flush;
    logic          walk_req;
    logic [VW-1:0] walk_vaddr;
    logic          walk_done;
    logic          replay;
    logic [VW-1:0] replay_vaddr;
    logic          mem_req;
    logic [PW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [IW-1:0] mem_rdata;
    logic          next_valid;
    logic [VW-1:0] next_pc;
    logic [IW-1:0] next_insn;
    logic          next_fault;
    logic          next_stall;

    int checks;
    int errors;

    fetch_insn_read_stage #(.VADDR_WIDTH(VW), .PADDR_WIDTH(PW), .INSN_WIDTH(IW)) dut (
        .clk(clk), .rstN(rstN),
        .prev_valid(prev_valid), .prev_tlbFault(prev_tlbFault), .prev_tlbMiss(prev_tlbMiss),
        .prev_pc_vaddr(prev_pc_vaddr), .prev_pc_paddr(prev_pc_paddr),
        .stall(stall), .flush(flush),
        .walk_req(walk_req), .walk_vaddr(walk_vaddr), .walk_done(walk_done),
        .replay(replay), .replay_vaddr(replay_vaddr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .next_valid(next_valid), .next_pc(next_pc), .next_insn(next_insn),
        .next_fault(next_fault), .next_stall(next_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        prev_valid    = 1'b0;
        prev_tlbFault = 1'b0;
        prev_tlbMiss  = 1'b0;
        prev_pc_vaddr = '0;
        prev_pc_paddr = '0;
        flush         = 1'b0;
        walk_done     = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        next_stall    = 1'b0;
    endtask

    task automatic drive_prev(input logic f, input logic m, input logic [VW-1:0] va,
                              input logic [PW-1:0] pa);
        prev_valid    = 1'b1;
        prev_tlbFault = f;
        prev_tlbMiss  = m;
        prev_pc_vaddr = va;
        prev_pc_paddr = pa;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_walk_req"}, 64'(walk_req), 64'd0);
        chk({tag, "_replay"}, 64'(replay), 64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_next_valid"}, 64'(next_valid), 64'd0);
    endtask

    // One complete fetch starting just after a negedge with the stage empty.
    // kind: 0 = normal read, 1 = translation fault, 2 = TLB miss.
    task automatic do_fetch(input int kind, input logic [VW-1:0] va, input logic [PW-1:0] pa,
                            input logic [IW-1:0] data, input int gdly, input int rdly,
                            input int wdly, input int sdly);
        logic [IW-1:0] exp_insn;
        logic          exp_fault;
        drive_prev(kind == 1, (kind == 2) || ((kind == 1) && ($urandom_range(0, 1) == 1)), va, pa);
        #1 chk("accept_stall", 64'(stall), 64'd0);
        @(negedge clk);
        idle_inputs();
        if (kind == 2) begin
            for (int i = 1; i <= wdly; i++) begin
                chk("walk_req", 64'(walk_req), 64'd1);
                chk("walk_vaddr", 64'(walk_vaddr), 64'(va));
                chk("walk_no_mem", 64'(mem_req), 64'd0);
                chk("walk_no_out", 64'(next_valid), 64'd0);
                chk("walk_stall", 64'(stall), 64'd1);
                if (i == wdly) walk_done = 1'b1;
                @(negedge clk);
            end
            walk_done = 1'b0;
            chk("replay_pulse", 64'(replay), 64'd1);
            chk("replay_vaddr", 64'(replay_vaddr), 64'(va));
            chk("replay_walk_off", 64'(walk_req), 64'd0);
            chk("replay_no_out", 64'(next_valid), 64'd0);
            @(negedge clk);
            chk("replay_once", 64'(replay), 64'd0);
            return;
        end
        if (kind == 1) begin
            exp_insn  = '0;
            exp_fault = 1'b1;
            chk("fault_no_mem", 64'(mem_req), 64'd0);
            chk("fault_no_walk", 64'(walk_req), 64'd0);
        end else begin
            exp_insn  = data;
            exp_fault = 1'b0;
            for (int i = 0; i <= gdly; i++) begin
                chk("req_mem_req", 64'(mem_req), 64'd1);
                chk("req_mem_addr", 64'(mem_addr), 64'(pa));
                chk("req_stall", 64'(stall), 64'd1);
                chk("req_no_out", 64'(next_valid), 64'd0);
                if (i == gdly) mem_gnt = 1'b1;
                @(negedge clk);
            end
            mem_gnt = 1'b0;
            for (int j = 0; j <= rdly; j++) begin
                chk("wait_mem_req", 64'(mem_req), 64'd0);
                chk("wait_stall", 64'(stall), 64'd1);
                chk("wait_no_out", 64'(next_valid), 64'd0);
                if (j == rdly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = data;
                end
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        for (int k = 0; k <= sdly; k++) begin
            next_stall = (k < sdly);
            #1;
            chk("out_valid", 64'(next_valid), 64'd1);
            chk("out_pc", 64'(next_pc), 64'(va));
            chk("out_insn", 64'(next_insn), 64'(exp_insn));
            chk("out_fault", 64'(next_fault), 64'(exp_fault));
            chk("out_stall", 64'(stall), 64'(k < sdly));
            @(negedge clk);
        end
        next_stall = 1'b0;
        chk("out_consumed", 64'(next_valid), 64'd0);
    endtask

    initial begin
        logic [VW-1:0] va;
        logic [PW-1:0] pa;
        logic [IW-1:0] d;
        checks = 0;
        errors = 0;
        idle_inputs();
        rstN = 1'b0;
        #12;
        check_idle_outputs("reset");
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_pc", 64'(next_pc), 64'd0);
        chk("reset_insn", 64'(next_insn), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Normal fetch, zero-wait memory: next_valid three cycles after acceptance
        do_fetch(0, 32'h0000_1000, 34'h0_0000_1000, 32'h0000_0013, 0, 0, 0, 0);

        // Fault has priority over miss
        do_fetch(1, 32'h8000_0000, 34'h0, 32'h0, 0, 0, 0, 0);

        // Miss: walk_req for five cycles then a single replay pulse
        do_fetch(2, 32'h0000_2004, 34'h0, 32'h0, 0, 0, 5, 0);

        // Back-pressure then same-cycle acceptance of a new entry
        drive_prev(1'b1, 1'b0, 32'h0000_4000, 34'h0);
        @(negedge clk);
        idle_inputs();
        next_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_stall", 64'(stall), 64'd1);
            chk("bp_valid", 64'(next_valid), 64'd1);
            chk("bp_pc", 64'(next_pc), 64'h4000);
            chk("bp_fault", 64'(next_fault), 64'd1);
            @(negedge clk);
        end
        next_stall = 1'b0;
        drive_prev(1'b0, 1'b0, 32'h0000_5000, 34'h3_0000_5000);
        #1 chk("bp_release_stall", 64'(stall), 64'd0);
        @(negedge clk);
        idle_inputs();
        chk("bp_next_mem_req", 64'(mem_req), 64'd1);
        chk("bp_next_mem_addr", 64'(mem_addr), 64'h3_0000_5000);
        chk("bp_old_gone", 64'(next_valid), 64'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        @(negedge clk);
        idle_inputs();
        chk("bp_new_valid", 64'(next_valid), 64'd1);
        chk("bp_new_pc", 64'(next_pc), 64'h5000);
        chk("bp_new_insn", 64'(next_insn), 64'hCAFE_0001);
        @(negedge clk);

        // Flush in WAIT: read data is discarded and stall releases after rvalid
        drive_prev(1'b0, 1'b0, 32'h0000_6000, 34'h0_0000_6000);
        @(negedge clk);
        idle_inputs();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fw_drain_stall", 64'(stall), 64'd1);
        chk("fw_drain_valid", 64'(next_valid), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1 chk("fw_rvalid_stall", 64'(stall), 64'd1);
        @(negedge clk);
        idle_inputs();
        chk("fw_release_stall", 64'(stall), 64'd0);
        chk("fw_no_out", 64'(next_valid), 64'd0);
        @(negedge clk);
        chk("fw_still_no_out", 64'(next_valid), 64'd0);

        // Flush in REQ without grant drops the request
        drive_prev(1'b0, 1'b0, 32'h0000_7000, 34'h0_0000_7000);
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fr_mem_req", 64'(mem_req), 64'd0);
        chk("fr_stall", 64'(stall), 64'd0);

        // Flush in WALK keeps walk_req until walk_done and suppresses the replay
        drive_prev(1'b0, 1'b1, 32'h0000_8000, 34'h0);
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fk_walk_req", 64'(walk_req), 64'd1);
        chk("fk_stall", 64'(stall), 64'd1);
        @(negedge clk);
        walk_done = 1'b1;
        @(negedge clk);
        walk_done = 1'b0;
        chk("fk_walk_off", 64'(walk_req), 64'd0);
        chk("fk_no_replay", 64'(replay), 64'd0);
        chk("fk_idle_stall", 64'(stall), 64'd0);

        // Asynchronous reset during a walk
        drive_prev(1'b0, 1'b1, 32'h0000_3000, 34'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("rst_walk_before", 64'(walk_req), 64'd1);
        #2 rstN = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        chk("rst_async_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        do_fetch(0, 32'h0000_9000, 34'h1_0000_9000, 32'h1234_5678, 1, 1, 0, 1);

        // Random fetches
        for (int n = 0; n < 40; n++) begin
            va = $urandom;
            pa = {2'($urandom_range(0, 3)), 32'($urandom)};
            d  = $urandom;
            do_fetch(int'($urandom_range(0, 2)), va, pa, d, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_insn_read_stage.md
Name: fetch_insn_read_stage

Overview:
- Consumer end of the fetch address-translate stage output bundle: valid, tlbFault, tlbMiss, pc_vaddr, pc_paddr.
- Per translated fetch: issues one instruction-memory read, requests a page walk on TLB miss, or forwards a fault.
- Presents one instruction (or fault) per fetch to the decode side.
- Back-pressures the translate stage while busy.

Parameters:
VADDR_WIDTH, 32, virtual PC width
PADDR_WIDTH, 34, physical address width (Sv32)
INSN_WIDTH, 32, instruction / memory data width

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
prev_valid  in  1  translate-stage entry valid
prev_tlbFault  in  1  translation fault
prev_tlbMiss  in  1  TLB miss
prev_pc_vaddr  in  VADDR_WIDTH  fetch PC, virtual
prev_pc_paddr  in  PADDR_WIDTH  fetch PC, physical
stall  out  1  translate stage must hold its outputs (comb)
flush  in  1  discard all in-flight work
walk_req  out  1  page-walk request, level
walk_vaddr  out  VADDR_WIDTH  address to walk
walk_done  in  1  walk complete, 1-cycle pulse
replay  out  1  1-cycle pulse: re-translate replay_vaddr
replay_vaddr  out  VADDR_WIDTH  PC to re-translate
mem_req  out  1  read request
mem_addr  out  PADDR_WIDTH  read address
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid, strictly after gnt
mem_rdata  in  INSN_WIDTH  read data
next_valid  out  1  output entry valid
next_pc  out  VADDR_WIDTH  entry PC
next_insn  out  INSN_WIDTH  instruction, 0 on fault
next_fault  out  1  instruction page fault
next_stall  in  1  decode cannot accept

Behaviour:
- Reset (rstN=0, async): state=IDLE; all registered outputs 0 (walk_req, replay, mem_req, next_valid, next_fault, next_pc, next_insn, walk_vaddr, replay_vaddr, mem_addr). The pc/paddr latches are also cleared to 0.
- States: IDLE, WALK, REQ, WAIT, OUT, DRAIN.
- Accept condition: acc = prev_valid & !flush & (state==IDLE | (state==OUT & !next_stall)). On acc, latch vaddr/paddr. Next state by priority:
  - tlbFault -> OUT, next_fault=1, next_insn=0.
  - else tlbMiss -> WALK.
  - else -> REQ.
- stall = !(state==IDLE | (state==OUT & !next_stall)). It is combinational and does not depend on prev_valid.
- WALK: walk_req=1, walk_vaddr=latched vaddr.
  - On walk_done: replay=1 next cycle with replay_vaddr=latched vaddr; -> IDLE.
  - No instruction output for a miss.
- REQ: mem_req=1, mem_addr=latched paddr; hold until mem_gnt. On gnt -> WAIT.
- WAIT: on mem_rvalid, latch rdata into next_insn, next_fault=0 -> OUT.
- OUT: next_valid=1 with next_pc/next_insn/next_fault stable.
  - While next_stall=1: hold.
  - When next_stall=0: entry consumed this cycle; -> IDLE unless acc.
- Latency (no stalls, gnt in REQ cycle, rvalid one cycle later): acc at T0, REQ T1, WAIT T2, next_valid T3. Fault: next_valid T1. Miss: walk_req from T1.
- Flush (synchronous, highest priority, prev inputs ignored that cycle):
  - IDLE / OUT / REQ without same-cycle gnt -> IDLE. next_valid=0 and mem_req=0 next cycle.
  - REQ with same-cycle gnt, or WAIT -> DRAIN. DRAIN keeps stall=1, discards the next mem_rvalid, then -> IDLE.
  - WALK -> DRAIN with walk flag. walk_req stays 1 until walk_done; replay is suppressed; then -> IDLE.
  - Flush while in DRAIN: no effect.
- Simultaneous mem_gnt and mem_rvalid in REQ: protocol violation, not handled.
- At most one outstanding memory read and one walk. Never both.

Test Plan:
- Normal fetch: prev_valid, vaddr=0x1000, paddr=0x0_0000_1000, gnt same cycle, rvalid+rdata=0x00000013 next cycle -> mem_addr=0x1000, next_valid at T3 with next_pc=0x1000, next_insn=0x13, fault=0; stall=1 during T1-T2.
- Fault priority: tlbFault=1 and tlbMiss=1, vaddr=0x8000_0000 -> next_valid at T1, next_fault=1, next_insn=0; no walk_req, no mem_req.
- Miss and replay: tlbMiss, vaddr=0x2004; walk_done 5 cycles later -> walk_req=1 for 5 cycles with walk_vaddr=0x2004, then replay pulse exactly 1 cycle with replay_vaddr=0x2004; next_valid stays 0.
- Back-pressure: next_stall=1 for 4 cycles in OUT -> outputs stable, stall=1. When next_stall drops and prev_valid=1 same cycle, the new entry is accepted with no bubble.
- Flush in WAIT: flush one cycle after gnt, rvalid 2 cycles later -> DRAIN; rvalid data discarded, next_valid never 1, stall released the cycle after rvalid.
- Reset mid-operation: rstN low during WALK -> walk_req, next_valid, replay, mem_req 0 immediately (async); after release, the stage accepts a new fetch from IDLE.
